mem_lock_arbiter: RTL and testbench

- Shared-resource arbiter between NCORE pipelined 16-bit cores, the single main memory, and the hardware lock table.
- Each core's decode stage raises a memory read/write request or a lock/unlock request; this block serialises them.
- It drives the single-port synchronous main memory and returns per-core acks, which are the cores' main_mem_ac / lock_ac inputs.
- Memory and lock paths are independent; each has its own round-robin pointer.

---
 rtl/mem_lock_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mem_lock_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lock_arbiter.sv
// mem_lock_arbiter
//   Serialises the cores' main-memory reads/writes onto one single-port
//   synchronous memory and arbitrates lock/unlock requests against a
//   hardware lock table. The memory and lock paths are independent and
//   each has its own round-robin pointer.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   rd_req, wr_req        per-core memory requests (level, held until ack)
//   req_adr, req_wdat     per-core address / write data, core i at [16i+:16]
//   mem_ack               one-cycle per-core pulse, access complete
//   mem_rdat_out          read data, valid with mem_ack (0 for writes)
//   mem_adr, mem_wdat     memory address / write data (driven while busy)
//   mem_re, mem_we        memory strobes
//   mem_rdat              memory read data, valid in the last busy cycle
//   lock_req, unlock_req  per-core lock table requests (level)
//   lock_adr_in           per-core 4-bit lock slot number
//   lock_ack              one-cycle per-core pulse, lock/unlock done
//   lock_err              one-cycle pulse with the ack, unlock by non-owner
module mem_lock_arbiter #(
  parameter int NCORE   = 2,
  parameter int MEM_LAT = 2,
  parameter int NLOCK   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCORE-1:0]     rd_req,
  input  logic [NCORE-1:0]     wr_req,
  input  logic [16*NCORE-1:0]  req_adr,
  input  logic [16*NCORE-1:0]  req_wdat,
  output logic [NCORE-1:0]     mem_ack,
  output logic [15:0]          mem_rdat_out,
  output logic [15:0]          mem_adr,
  output logic [15:0]          mem_wdat,
  output logic                 mem_re,
  output logic                 mem_we,
  input  logic [15:0]          mem_rdat,
  input  logic [NCORE-1:0]     lock_req,
  input  logic [NCORE-1:0]     unlock_req,
  input  logic [4*NCORE-1:0]   lock_adr_in,
  output logic [NCORE-1:0]     lock_ack,
  output logic                 lock_err
);

  localparam int IW  = $clog2(NCORE);
  localparam int IW1 = IW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Returns {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [NCORE-1:0] req,
                                          input logic [IW-1:0]    ptr);
    logic          found;
    logic [IW-1:0] sel;
    logic [IW:0]   idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NCORE; k++) begin
      idx = {1'b0, ptr} + IW1'(k);
      if (idx >= IW1'(NCORE)) idx = idx - IW1'(NCORE);
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IW-1:0];
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
    return (g == IW'(NCORE - 1)) ? '0 : g + 1'b1;
  endfunction

  // ---------------- memory path ----------------
  logic [1:0]    state_reg;
  logic [IW-1:0] grant_reg;
  logic [IW-1:0] mem_rr_reg;
  logic [15:0]   adr_reg;
  logic [15:0]   wdat_reg;
  logic [15:0]   rdat_reg;
  logic          we_reg;
  logic [2:0]    cnt_reg;

  logic [IW:0]   mem_pick;
  logic [IW-1:0] mem_sel;

  assign mem_pick = rr_pick(rd_req | wr_req, mem_rr_reg);
  assign mem_sel  = mem_pick[IW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      grant_reg  <= '0;
      mem_rr_reg <= '0;
      adr_reg    <= '0;
      wdat_reg   <= '0;
      rdat_reg   <= '0;
      we_reg     <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (mem_pick[IW]) begin
            grant_reg <= mem_sel;
            adr_reg   <= req_adr[16*mem_sel +: 16];
            wdat_reg  <= req_wdat[16*mem_sel +: 16];
            we_reg    <= wr_req[mem_sel];   // rd+wr together counts as a write
            cnt_reg   <= 3'(MEM_LAT - 1);
            state_reg <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_reg == 3'd0) begin
            rdat_reg  <= mem_rdat;
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_DONE: begin
          mem_rr_reg <= rr_next(grant_reg);
          state_reg  <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so reset silences them immediately.
  assign mem_re       = (state_reg == S_BUSY) && !we_reg;
  assign mem_we       = (state_reg == S_BUSY) && we_reg;
  assign mem_adr      = (state_reg == S_BUSY) ? adr_reg  : 16'h0000;
  assign mem_wdat     = (state_reg == S_BUSY) ? wdat_reg : 16'h0000;
  assign mem_rdat_out = (state_reg == S_DONE && !we_reg) ? rdat_reg : 16'h0000;

  always_comb begin
    mem_ack = '0;
    if (state_reg == S_DONE) mem_ack[grant_reg] = 1'b1;
  end

  // ---------------- lock path ----------------
  logic              valid_reg [NLOCK];
  logic [IW-1:0]     owner_reg [NLOCK];
  logic [IW-1:0]     lock_rr_reg;
  logic [NCORE-1:0]  lock_ack_reg;
  logic              lock_err_reg;

  logic [IW:0]       lk_pick;
  logic [IW-1:0]     lk_sel;
  logic [3:0]        lk_slot;
  logic              lk_owned;
  logic [NLOCK-1:0]  lk_set;
  logic [NLOCK-1:0]  lk_clr;
  logic [NCORE-1:0]  lock_ack_next;
  logic              lock_err_next;

  assign lk_pick  = rr_pick(lock_req | unlock_req, lock_rr_reg);
  assign lk_sel   = lk_pick[IW-1:0];
  assign lk_slot  = lock_adr_in[4*lk_sel +: 4];
  assign lk_owned = valid_reg[lk_slot] && (owner_reg[lk_slot] == lk_sel);

  always_comb begin
    lk_set        = '0;
    lk_clr        = '0;
    lock_ack_next = '0;
    lock_err_next = 1'b0;
    if (lk_pick[IW]) begin
      if (unlock_req[lk_sel]) begin
        // Unlock always acks; a non-owner only gets the error flag.
        lock_ack_next[lk_sel] = 1'b1;
        if (lk_owned) lk_clr[lk_slot] = 1'b1;
        else          lock_err_next   = 1'b1;
      end else if (!valid_reg[lk_slot] || lk_owned) begin
        lock_ack_next[lk_sel] = 1'b1;
        lk_set[lk_slot]       = 1'b1;
      end
      // Otherwise held by another core: silent, the core keeps retrying.
    end
  end

  // Pointer moves on every requesting cycle, even a blocked grant, so a
  // core spinning on a held lock cannot starve the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_rr_reg  <= '0;
      lock_ack_reg <= '0;
      lock_err_reg <= 1'b0;
    end else begin
      lock_ack_reg <= lock_ack_next;
      lock_err_reg <= lock_err_next;
      if (lk_pick[IW]) lock_rr_reg <= rr_next(lk_sel);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NLOCK; gi++) begin : g_slot
      always_ff @(posedge clk or posedge reset) begin
        if (reset)           valid_reg[gi] <= 1'b0;
        else if (lk_set[gi]) valid_reg[gi] <= 1'b1;
        else if (lk_clr[gi]) valid_reg[gi] <= 1'b0;
      end

      // Owner is meaningless while the slot is invalid, so it needs no reset.
      always_ff @(posedge clk) begin
        if (lk_set[gi]) owner_reg[gi] <= lk_sel;
      end
    end
  endgenerate

  assign lock_ack = lock_ack_reg;
  assign lock_err = lock_err_reg;

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Testbench for mem_lock_arbiter: directed steps with a memory scoreboard
// and a lock scoreboard, both checked by negedge monitors.
module tb_mem_lock_arbiter;

  localparam int NCORE   = 2;
  localparam int MEM_LAT = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NCORE-1:0]    rd_req, wr_req;
  logic [16*NCORE-1:0] req_adr, req_wdat;
  logic [NCORE-1:0]    mem_ack;
  logic [15:0]         mem_rdat_out, mem_adr, mem_wdat, mem_rdat;
  logic                mem_re, mem_we;
  logic [NCORE-1:0]    lock_req, unlock_req;
  logic [4*NCORE-1:0]  lock_adr_in;
  logic [NCORE-1:0]    lock_ack;
  logic                lock_err;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int          core;
    logic        we;
    logic [15:0] adr;
    logic [15:0] wdat;
    logic [15:0] rdat;
  } mem_exp_t;

  typedef struct {
    int   core;
    logic err;
  } lock_exp_t;

  mem_exp_t  mq[$];
  lock_exp_t lq[$];

  mem_lock_arbiter #(.NCORE(NCORE), .MEM_LAT(MEM_LAT), .NLOCK(16)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .wr_req(wr_req), .req_adr(req_adr), .req_wdat(req_wdat),
    .mem_ack(mem_ack), .mem_rdat_out(mem_rdat_out),
    .mem_adr(mem_adr), .mem_wdat(mem_wdat), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdat(mem_rdat),
    .lock_req(lock_req), .unlock_req(unlock_req), .lock_adr_in(lock_adr_in),
    .lock_ack(lock_ack), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  // Memory contents seen by reads; 0x0010 holds 0xBEEF.
  function automatic logic [15:0] rdv(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // Memory model: data only valid in the final busy cycle, garbage before.
  int busy_cyc;
  always @(posedge clk or posedge reset) begin
    if (reset)                busy_cyc <= 0;
    else if (mem_re || mem_we) busy_cyc <= busy_cyc + 1;
    else                      busy_cyc <= 0;
  end
  assign mem_rdat = (mem_re && busy_cyc == MEM_LAT - 1) ? rdv(mem_adr) : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory monitor: strobe contents, ack core, read data and latency.
  int strobe_cnt;
  always @(negedge clk) begin : mem_mon
    mem_exp_t e;
    if (reset) begin
      strobe_cnt <= 0;
    end else begin
      if (mem_re || mem_we) begin
        if (mq.size() == 0) begin
          check("strobe_unexpected", {30'd0, mem_re, mem_we}, 32'd0);
        end else begin
          e = mq[0];
          check("strobe_adr", {16'd0, mem_adr}, {16'd0, e.adr});
          check("strobe_we", {31'd0, mem_we}, {31'd0, e.we});
          check("strobe_re", {31'd0, mem_re}, {31'd0, !e.we});
          if (e.we) check("strobe_wdat", {16'd0, mem_wdat}, {16'd0, e.wdat});
        end
        strobe_cnt <= strobe_cnt + 1;
      end
      if (|mem_ack) begin
        check("ack_onehot", {31'd0, $onehot(mem_ack)}, 32'd1);
        if (mq.size() == 0) begin
          check("ack_unexpected", {30'd0, mem_ack}, 32'd0);
        end else begin
          e = mq.pop_front();
          check("ack_core", {30'd0, mem_ack}, 32'd1 << e.core);
          check("ack_rdat", {16'd0, mem_rdat_out}, {16'd0, e.rdat});
          check("ack_strobe_cycles", strobe_cnt, MEM_LAT);
        end
        strobe_cnt <= 0;
      end
    end
  end

  // Lock monitor: every ack must match the next expected entry.
  always @(negedge clk) begin : lock_mon
    lock_exp_t le;
    if (!reset) begin
      if (|lock_ack) begin
        if (lq.size() == 0) begin
          check("lock_ack_unexpected", {30'd0, lock_ack}, 32'd0);
        end else begin
          le = lq.pop_front();
          check("lock_ack_core", {30'd0, lock_ack}, 32'd1 << le.core);
          check("lock_err_flag", {31'd0, lock_err}, {31'd0, le.err});
        end
      end else if (lock_err) begin
        check("lock_err_alone", {31'd0, lock_err}, 32'd0);
      end
    end
  end

  task automatic push_mem(input int core, input logic we, input logic [15:0] adr,
                          input logic [15:0] wdat);
    mem_exp_t e;
    e.core = core; e.we = we; e.adr = adr; e.wdat = wdat;
    e.rdat = we ? 16'h0000 : rdv(adr);
    mq.push_back(e);
    req_adr[16*core +: 16]  = adr;
    req_wdat[16*core +: 16] = wdat;
  endtask

  task automatic push_lock(input int core, input logic err);
    lock_exp_t le;
    le.core = core; le.err = err;
    lq.push_back(le);
  endtask

  // Wait for n memory acks; drop each acked core's request unless hold is set.
  task automatic run_mem(input int n, input bit hold, input string tag);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (|mem_ack) begin
        got++;
        if (!hold) begin
          rd_req = rd_req & ~mem_ack;
          wr_req = wr_req & ~mem_ack;
        end
        if (got == n) begin
          rd_req = '0;
          wr_req = '0;
        end
      end
    end
    check({tag, "_ack_count"}, got, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    rd_req = '0; wr_req = '0; req_adr = '0; req_wdat = '0;
    lock_req = '0; unlock_req = '0; lock_adr_in = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_ack", {30'd0, mem_ack}, 32'd0);
    check("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    check("rst_mem_adr", {16'd0, mem_adr}, 32'd0);
    check("rst_lock", {29'd0, lock_ack, lock_err}, 32'd0);
    reset = 1'b0;

    // 1: single read, latency MEM_LAT+1
    @(negedge clk);
    push_mem(0, 1'b0, 16'h0010, 16'h0000);
    rd_req[0] = 1'b1;
    @(negedge clk);
    check("t1_re_cycle1", {15'd0, mem_re, mem_adr}, {15'd0, 1'b1, 16'h0010});
    check("t1_no_ack_yet", {30'd0, mem_ack}, 32'd0);
    @(negedge clk);
    check("t1_re_cycle2", {15'd0, mem_re, mem_adr}, {15'd0, 1'b1, 16'h0010});
    @(negedge clk);
    check("t1_ack", {30'd0, mem_ack}, 32'd1);
    check("t1_rdat", {16'd0, mem_rdat_out}, 32'h0000BEEF);
    rd_req[0] = 1'b0;
    @(negedge clk);
    check("t1_ack_pulse", {28'd0, mem_ack, mem_re, mem_we}, 32'd0);

    // fresh pointer for the alternation test
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // 2: both cores write continuously, grants alternate 0,1,0,1
    push_mem(0, 1'b1, 16'h0020, 16'h1111);
    push_mem(1, 1'b1, 16'h0021, 16'h2222);
    push_mem(0, 1'b1, 16'h0020, 16'h1111);
    push_mem(1, 1'b1, 16'h0021, 16'h2222);
    wr_req = 2'b11;
    run_mem(4, 1'b1, "t2");

    // 6: rd+wr together is a write
    push_mem(1, 1'b1, 16'h0030, 16'h00FF);
    rd_req[1] = 1'b1;
    wr_req[1] = 1'b1;
    run_mem(1, 1'b0, "t6");

    // 5: reset mid-access, then pointer restarts at core 0
    push_mem(0, 1'b0, 16'h0040, 16'h0000);
    rd_req[0] = 1'b1;
    run_mem(1, 1'b0, "t5_pre");
    push_mem(1, 1'b0, 16'h0050, 16'h0000);
    rd_req[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_busy", {31'd0, mem_re}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_strobes", {28'd0, mem_ack, mem_re, mem_we}, 32'd0);
    check("t5_rst_adr", {16'd0, mem_adr}, 32'd0);
    void'(mq.pop_back());
    push_mem(0, 1'b1, 16'h0060, 16'h6666);
    push_mem(1, 1'b0, 16'h0050, 16'h0000);
    wr_req[0] = 1'b1;
    @(negedge clk);
    check("t5_held_in_reset", {30'd0, mem_ack}, 32'd0);
    reset = 1'b0;
    run_mem(2, 1'b0, "t5_post");

    // 3: core1 locks slot 5, core0 blocked until core1 unlocks
    @(negedge clk);
    push_lock(1, 1'b0);
    lock_adr_in[7:4] = 4'd5;
    lock_req[1] = 1'b1;
    @(negedge clk);
    check("t3_lock1", {29'd0, lock_ack, lock_err}, {29'd0, 2'b10, 1'b0});
    lock_req[1] = 1'b0;
    lock_adr_in[3:0] = 4'd5;
    lock_req[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_blocked", {30'd0, lock_ack}, 32'd0);
    end
    push_lock(1, 1'b0);
    push_lock(0, 1'b0);
    unlock_req[1] = 1'b1;
    @(negedge clk);
    check("t3_unlock1", {29'd0, lock_ack, lock_err}, {29'd0, 2'b10, 1'b0});
    unlock_req[1] = 1'b0;
    @(negedge clk);
    check("t3_lock0", {29'd0, lock_ack, lock_err}, {29'd0, 2'b01, 1'b0});
    lock_req[0] = 1'b0;
    @(negedge clk);
    check("t3_idle", {29'd0, lock_ack, lock_err}, 32'd0);

    // 4: unlock of a free slot errors and leaves it free
    push_lock(0, 1'b1);
    lock_adr_in[3:0] = 4'd3;
    unlock_req[0] = 1'b1;
    @(negedge clk);
    check("t4_unlock_free", {29'd0, lock_ack, lock_err}, {29'd0, 2'b01, 1'b1});
    unlock_req[0] = 1'b0;
    push_lock(1, 1'b0);
    lock_adr_in[7:4] = 4'd3;
    lock_req[1] = 1'b1;
    @(negedge clk);
    check("t4_lock_after", {29'd0, lock_ack, lock_err}, {29'd0, 2'b10, 1'b0});
    lock_req[1] = 1'b0;

    // non-owner unlock of slot 5 (held by core0) errors
    push_lock(1, 1'b1);
    lock_adr_in[7:4] = 4'd5;
    unlock_req[1] = 1'b1;
    @(negedge clk);
    check("t4_nonowner", {29'd0, lock_ack, lock_err}, {29'd0, 2'b10, 1'b1});
    unlock_req[1] = 1'b0;

    // lock+unlock together: unlock wins, so slot 5 frees and core1 gets it
    push_lock(0, 1'b0);
    lock_adr_in[3:0] = 4'd5;
    lock_req[0] = 1'b1;
    unlock_req[0] = 1'b1;
    @(negedge clk);
    check("t4_both_ack", {29'd0, lock_ack, lock_err}, {29'd0, 2'b01, 1'b0});
    lock_req[0] = 1'b0;
    unlock_req[0] = 1'b0;
    push_lock(1, 1'b0);
    lock_req[1] = 1'b1;
    @(negedge clk);
    check("t4_relock", {29'd0, lock_ack, lock_err}, {29'd0, 2'b10, 1'b0});
    lock_req[1] = 1'b0;

    repeat (3) @(negedge clk);
    check("mem_queue_empty", mq.size(), 0);
    check("lock_queue_empty", lq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
